// File: rtl/mux_4x1_rr_arbiter_if.sv
// mux_4x1_rr_arbiter_if
// Purpose : bundles the request/grant/select signals between the four
//           requesters and the round-robin arbiter that owns the 4x1 mux select.
// Signals : Req[3:0]   request vector, bit i = requester i wants the mux
//           Grant[3:0] one-hot grant (0000 when idle)
//           S1, S0     mux select, {S1,S0} = granted index
//           Busy       a grant is currently held
//           Switch     one-cycle pulse when Grant takes a new nonzero value
// Modports: master = requester side, slave = arbiter side.
interface mux_4x1_rr_arbiter_if;
   logic [3:0] Req;
   logic [3:0] Grant;
   logic       S1;
   logic       S0;
   logic       Busy;
   logic       Switch;

   modport master (
      output Req,
      input  Grant, S1, S0, Busy, Switch
   );

   modport slave (
      input  Req,
      output Grant, S1, S0, Busy, Switch
   );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter
// Purpose : round-robin controller sharing the 2-bit 4x1 mux between four
//           requesters (0->A, 1->B, 2->C, 3->D). A hold counter caps each
//           tenure at HOLD_MAX cycles so no requester can starve the others.
// Ports   : Clk  system clock, rising edge
//           Rst  asynchronous active-high reset
//           bus  slave modport of mux_4x1_rr_arbiter_if
//                (Req in; Grant, S1, S0, Busy, Switch out, all registered)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no grant held; any request is granted at the next edge
// ST_BUSY | one requester holds the mux; re-arbitrate only on release
module mux_4x1_rr_arbiter #(
   parameter int HOLD_MAX = 4
) (
   input  logic                         Clk,
   input  logic                         Rst,
   mux_4x1_rr_arbiter_if.slave          bus
);

   localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t     r_state;
   logic [3:0] r_grant;
   logic [1:0] r_sel;
   logic       r_busy;
   logic       r_switch;
   logic [1:0] r_ptr;
   logic [3:0] r_hold;

   state_t     w_state_nxt;
   logic [3:0] w_grant_nxt;
   logic [1:0] w_sel_nxt;
   logic       w_busy_nxt;
   logic       w_switch_nxt;
   logic [1:0] w_ptr_nxt;
   logic [3:0] w_hold_nxt;

   logic       w_release;
   logic [1:0] w_base;
   logic       w_found;
   logic [1:0] w_win;

   // On release the pointer moves to g+1, and the search must already use
   // that new pointer so the outgoing requester ranks last.
   assign w_release = (r_state == ST_BUSY) &&
                      (!bus.Req[r_sel] || (r_hold == HOLD_MAX_C));
   assign w_base    = (r_state == ST_BUSY) ? (r_sel + 2'd1) : r_ptr;

   always_comb begin
      logic [1:0] idx;
      w_found = 1'b0;
      w_win   = 2'd0;
      idx     = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = w_base + 2'(k);
         if (!w_found && bus.Req[idx]) begin
            w_found = 1'b1;
            w_win   = idx;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state  <= ST_IDLE;
         r_grant  <= 4'b0000;
         r_sel    <= 2'd0;
         r_busy   <= 1'b0;
         r_switch <= 1'b0;
         r_ptr    <= 2'd0;
         r_hold   <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_sel    <= w_sel_nxt;
         r_busy   <= w_busy_nxt;
         r_switch <= w_switch_nxt;
         r_ptr    <= w_ptr_nxt;
         r_hold   <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_found) w_state_nxt = ST_BUSY;
         ST_BUSY: if (w_release && !w_found) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_grant_nxt  = r_grant;
      w_sel_nxt    = r_sel;
      w_busy_nxt   = r_busy;
      w_switch_nxt = 1'b0;
      w_ptr_nxt    = r_ptr;
      w_hold_nxt   = r_hold;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_grant_nxt  = 4'b0001 << w_win;
               w_sel_nxt    = w_win;
               w_busy_nxt   = 1'b1;
               w_switch_nxt = 1'b1;
               w_hold_nxt   = 4'd1;
            end else begin
               w_grant_nxt = 4'b0000;
               w_busy_nxt  = 1'b0;
            end
         end
         ST_BUSY: begin
            if (w_release) begin
               w_ptr_nxt = r_sel + 2'd1;
               if (w_found) begin
                  // A sole remaining requester is re-granted without a pulse.
                  w_grant_nxt  = 4'b0001 << w_win;
                  w_sel_nxt    = w_win;
                  w_switch_nxt = (w_win != r_sel);
                  w_hold_nxt   = 4'd1;
               end else begin
                  // Select lines keep their last value while idle.
                  w_grant_nxt = 4'b0000;
                  w_busy_nxt  = 1'b0;
                  w_hold_nxt  = 4'd0;
               end
            end else begin
               w_hold_nxt = r_hold + 4'd1;
            end
         end
         default: ;
      endcase
   end

   assign bus.Grant  = r_grant;
   assign bus.S1     = r_sel[1];
   assign bus.S0     = r_sel[0];
   assign bus.Busy   = r_busy;
   assign bus.Switch = r_switch;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// tb_mux_4x1_rr_arbiter
// Drives two arbiters (HOLD_MAX=4 and HOLD_MAX=1) with the same request
// stream and compares every output against a behavioural reference model.
module tb_mux_4x1_rr_arbiter;

   logic Clk;
   logic Rst;

   mux_4x1_rr_arbiter_if ifa ();
   mux_4x1_rr_arbiter_if ifb ();

   mux_4x1_rr_arbiter #(.HOLD_MAX(4)) dut_h4 (.Clk(Clk), .Rst(Rst), .bus(ifa));
   mux_4x1_rr_arbiter #(.HOLD_MAX(1)) dut_h1 (.Clk(Clk), .Rst(Rst), .bus(ifb));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state, index 0 -> HOLD_MAX=4, index 1 -> HOLD_MAX=1
   int hmax   [2] = '{4, 1};
   int m_owner[2];   // -1 when idle
   int m_ptr  [2];
   int m_ten  [2];   // cycles of current tenure
   int m_sel  [2];
   int m_sw   [2];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int rr_search(input int ptr, input logic [3:0] req);
      for (int k = 0; k < 4; k++)
         if (req[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1; m_ptr[d] = 0; m_ten[d] = 0; m_sel[d] = 0; m_sw[d] = 0;
      end
   endtask

   task automatic model_step(input logic [3:0] req);
      int w;
      for (int d = 0; d < 2; d++) begin
         if (m_owner[d] < 0) begin
            w = rr_search(m_ptr[d], req);
            if (w >= 0) begin
               m_owner[d] = w; m_ten[d] = 1; m_sel[d] = w; m_sw[d] = 1;
            end else begin
               m_sw[d] = 0;
            end
         end else if (!req[m_owner[d]] || m_ten[d] == hmax[d]) begin
            m_ptr[d] = (m_owner[d] + 1) % 4;
            w = rr_search(m_ptr[d], req);
            if (w >= 0) begin
               m_sw[d] = (w != m_owner[d]) ? 1 : 0;
               m_owner[d] = w; m_ten[d] = 1; m_sel[d] = w;
            end else begin
               m_owner[d] = -1; m_ten[d] = 0; m_sw[d] = 0;
            end
         end else begin
            m_ten[d]++;
            m_sw[d] = 0;
         end
      end
   endtask

   task automatic check_dut(input int d, input logic [3:0] grant, input logic s1,
                            input logic s0, input logic busy, input logic sw);
      logic [3:0] exp_grant;
      exp_grant = (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
      check($sformatf("h%0d.grant", hmax[d]), 8'(grant), 8'(exp_grant));
      check($sformatf("h%0d.sel", hmax[d]), 8'({s1, s0}), 8'(m_sel[d]));
      check($sformatf("h%0d.busy", hmax[d]), 8'(busy), 8'(m_owner[d] >= 0));
      check($sformatf("h%0d.switch", hmax[d]), 8'(sw), 8'(m_sw[d]));
   endtask

   task automatic check_all();
      check_dut(0, ifa.Grant, ifa.S1, ifa.S0, ifa.Busy, ifa.Switch);
      check_dut(1, ifb.Grant, ifb.S1, ifb.S0, ifb.Busy, ifb.Switch);
   endtask

   // called at a negedge; returns at the following negedge
   task automatic tick(input logic [3:0] req);
      ifa.Req = req;
      ifb.Req = req;
      @(posedge Clk);
      model_step(req);
      #1;
      check_all();
      @(negedge Clk);
   endtask

   // asynchronous reset pulse placed between edges
   task automatic async_reset();
      #2;
      Rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   initial begin
      Rst = 1'b1;
      ifa.Req = 4'b0000;
      ifb.Req = 4'b0000;
      model_reset();

      // reset held for two edges
      for (int i = 0; i < 2; i++) begin
         @(posedge Clk);
         #1;
         check_all();
      end
      @(negedge Clk);
      Rst = 1'b0;

      // idle
      for (int i = 0; i < 5; i++) tick(4'b0000);

      // single requester, then Ptr=3 makes requester 3 win first
      for (int i = 0; i < 3; i++) tick(4'b0100);
      for (int i = 0; i < 2; i++) tick(4'b0000);
      tick(4'b1111);
      for (int i = 0; i < 2; i++) tick(4'b0000);

      // hold limit
      async_reset();
      for (int i = 0; i < 12; i++) tick(4'b0011);

      // pure round-robin on the HOLD_MAX=1 instance
      async_reset();
      for (int i = 0; i < 6; i++) tick(4'b1111);
      for (int i = 0; i < 2; i++) tick(4'b0000);

      // sole-requester regrant
      for (int i = 0; i < 10; i++) tick(4'b1000);
      for (int i = 0; i < 2; i++) tick(4'b0000);

      // reset mid-tenure
      tick(4'b0010);
      tick(4'b0010);
      async_reset();
      tick(4'b1111);
      tick(4'b1111);

      // randomized traffic, with sticky requests and occasional resets
      begin
         logic [3:0] req;
         req = 4'b0000;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) async_reset();
            tick(req);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
Round-robin controller that shares the 2-bit 4x1 multiplexer between four requesters. Requester 0 maps to mux input A, 1 to B, 2 to C and 3 to D. The block drives the mux select lines S1/S0 and returns a one-hot grant to the requesters. A hold counter caps any single tenure so no requester can starve the others. It sits beside Mux_4x1_2bit_beh/_gate, with S1/S0 wired directly to the mux select inputs.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one requester may hold the grant; legal range 1..15; the hold counter is 4 bits.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Rst  input  1  reset, asynchronous, active-high.
Req  input  4  request vector; Req[i] high means requester i wants the mux.
Grant  output  4  registered one-hot grant, or 0000 when idle.
S1  output  1  registered mux select MSB.
S0  output  1  registered mux select LSB; {S1,S0} = index of the granted requester.
Busy  output  1  registered; high while any grant is held.
Switch  output  1  registered one-cycle pulse on every cycle in which Grant takes a new nonzero value.

Behaviour:
- Reset (async, Rst=1): State=IDLE, Grant=0000, S1=0, S0=0, Busy=0, Switch=0, Ptr=0, HoldCnt=0. Rst deasserting mid-tenure restarts from IDLE with Ptr=0.
- Ptr is a 2-bit priority pointer. Search order is Ptr, Ptr+1, Ptr+2, Ptr+3, mod 4; the first Req bit set in that order wins.
- IDLE:
  - Req=0000 -> stay in IDLE, all outputs 0.
  - Any Req set -> at the next edge load the winner w: Grant=onehot(w), {S1,S0}=w, Busy=1, Switch=1, HoldCnt=1, State=BUSY.
  - Latency is one cycle from the Req edge to Grant.
- BUSY, granted index g. At each edge, evaluate in priority order:
  1. Release condition: Req[g]=0, or HoldCnt==HOLD_MAX.
  2. On release, Ptr<=g+1 mod 4. The search uses the new Ptr, so g ranks last.
     - If the search finds a winner w (w may equal g only if Req[g]=1 and no other Req is set): Grant=onehot(w), {S1,S0}=w, HoldCnt=1. Switch=1 if w!=g, else Switch=0. There is no idle bubble between tenures.
     - If no Req is set: State=IDLE, Grant=0000, Busy=0, Switch=0, {S1,S0} hold their last value.
  3. No release: Grant, S1 and S0 hold; HoldCnt+=1; Switch=0.
- Requests that arrive while another requester holds the grant are only considered at release.
- Grant is always one-hot or zero and always matches {S1,S0} whenever Busy=1.
- HOLD_MAX=1 gives pure per-cycle round-robin.
- HoldCnt never exceeds HOLD_MAX; it saturates by construction because the tenure is forced to release.
- All outputs come directly from flops; there are no combinational paths from Req to any output.

Test Plan:
1. Reset then idle: Rst=1 for 2 cycles, then Req=0000 for 5 cycles -> Grant=0000, S1S0=00, Busy=0, Switch=0 throughout.
2. Single requester: Req=0100 held 3 cycles, then 0000 -> one edge later Grant=0100, S1S0=10, Switch=1 for that cycle only. Grant holds for 3 cycles, then Busy=0 and Ptr=3.
3. Hold limit, HOLD_MAX=4: Req=0011 held constant -> Grant=0001 for 4 cycles, then 0010 for 4 cycles, then 0001 again. Switch pulses at each change; there are no idle cycles.
4. Round-robin fairness, HOLD_MAX=1: Req=1111 -> Grant sequence 0001, 0010, 0100, 1000, 0001 and S1S0 sequence 00, 01, 10, 11, 00, with Switch=1 every cycle.
5. Sole-requester regrant: Req=1000 held 10 cycles with HOLD_MAX=4 -> Grant=1000 throughout, Switch=1 on the first cycle only, and HoldCnt wraps 1..4 repeatedly.
6. Reset mid-tenure: Grant=0010, then Rst pulsed asynchronously between edges -> outputs clear immediately. After release with Req=1111, the first Grant=0001 because Ptr=0.
